// File: rtl/if_fetch_queue_pkg.sv
// Shared IF-stage types: per-instruction exception bits and the fetch queue slot layout.
package if_fetch_queue_pkg;

  localparam int          IF_QUEUE_DEPTH = 4;
  localparam logic [31:0] IF_RESET_PC    = 32'hbfc0_0000;

  typedef struct packed {
    logic AddrErrFetch;
  } ExceptinPipeType;

  typedef struct packed {
    logic [31:0]     pc;
    logic [31:0]     instr;
    ExceptinPipeType exc;
    logic            filled;
  } if_slot_t;

endpackage

// File: rtl/if_slot_ram.sv
// Fetch queue storage: DEPTH slots with an alloc write port, a fill write port and a head read port.
module if_slot_ram
  import if_fetch_queue_pkg::*;
#(
  parameter int DEPTH = IF_QUEUE_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             alloc_en,
  input  logic [PTR_W-1:0] alloc_idx,
  input  if_slot_t         alloc_slot,
  input  logic             fill_en,
  input  logic [PTR_W-1:0] fill_idx,
  input  logic [31:0]      fill_instr,
  input  logic             pop_en,
  input  logic [PTR_W-1:0] head_idx,
  output if_slot_t         head_slot
);

  if_slot_t slots_q [DEPTH];

  // Pop, alloc and fill never target the same slot in one cycle; the order below only matters
  // for robustness.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) slots_q[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) slots_q[i].filled <= 1'b0;
    end else begin
      if (pop_en) slots_q[head_idx].filled <= 1'b0;
      if (alloc_en) slots_q[alloc_idx] <= alloc_slot;
      if (fill_en) begin
        slots_q[fill_idx].instr  <= fill_instr;
        slots_q[fill_idx].filled <= 1'b1;
      end
    end
  end

  assign head_slot = slots_q[head_idx];

endmodule

// File: rtl/if_fetch_queue.sv
// IF-stage fetch unit: owns the fetch PC, issues in-order I-cache requests and queues the
// responses for ID_Reg; a flush redirects the PC and discards responses still in flight.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = IF_QUEUE_DEPTH,
  parameter logic [31:0] RESET_PC = IF_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            IF_Flush,
  input  logic [31:0]     IF_FlushPC,
  input  logic            ID_Wr,
  output logic            req_valid,
  output logic [31:0]     req_addr,
  input  logic            req_ready,
  input  logic            resp_valid,
  input  logic [31:0]     resp_data,
  output logic            IF_Valid,
  output logic [31:0]     IF_Instr,
  output logic [31:0]     IF_PC,
  output ExceptinPipeType IF_ExceptType
);

  localparam int              PTR_W   = $clog2(DEPTH);
  localparam int              CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [31:0]      pc_q;
  logic [PTR_W-1:0] head_q, tail_q, fill_idx;
  logic [CNT_W-1:0] alloc_cnt_q, out_cnt_q, discard_cnt_q;
  logic [CNT_W-1:0] discard_nxt;
  logic [CNT_W:0]   discard_total;
  logic             halt_q;
  logic             space, aligned, issue, mis_alloc, alloc, pop, resp_fill, resp_drop;
  if_slot_t         alloc_slot, head_slot;

  assign space     = alloc_cnt_q < DEPTH_C;
  assign aligned   = pc_q[1:0] == 2'b00;
  assign req_valid = rst && !IF_Flush && !halt_q && space && aligned;
  assign req_addr  = pc_q;
  assign issue     = req_valid && req_ready;
  assign mis_alloc = !IF_Flush && !halt_q && space && !aligned;
  assign alloc     = issue || mis_alloc;
  assign resp_drop = resp_valid && (discard_cnt_q != '0);
  assign resp_fill = resp_valid && (discard_cnt_q == '0);
  assign IF_Valid  = head_slot.filled;
  assign pop       = ID_Wr && IF_Valid && !IF_Flush;

  // Outstanding requests are the youngest allocations, except that a misaligned slot (which
  // halts fetch) sits behind them; that gives the oldest unfilled slot directly.
  assign fill_idx = tail_q - PTR_W'(out_cnt_q) - PTR_W'(halt_q);

  always_comb begin
    alloc_slot                  = '0;
    alloc_slot.pc               = pc_q;
    alloc_slot.exc.AddrErrFetch = !aligned;
    alloc_slot.filled           = !aligned;
  end

  // On flush every request still owed a response must be discarded, minus one answered now.
  always_comb begin
    discard_total = {1'b0, discard_cnt_q} + {1'b0, out_cnt_q};
    if (resp_valid && discard_total != '0) discard_total = discard_total - 1'b1;
    discard_nxt = (discard_total > {1'b0, DEPTH_C}) ? DEPTH_C : discard_total[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q          <= RESET_PC;
      head_q        <= '0;
      tail_q        <= '0;
      alloc_cnt_q   <= '0;
      out_cnt_q     <= '0;
      discard_cnt_q <= '0;
      halt_q        <= 1'b0;
    end else if (IF_Flush) begin
      pc_q          <= IF_FlushPC;
      head_q        <= '0;
      tail_q        <= '0;
      alloc_cnt_q   <= '0;
      out_cnt_q     <= '0;
      discard_cnt_q <= discard_nxt;
      halt_q        <= 1'b0;
    end else begin
      if (issue) pc_q <= pc_q + 32'd4;
      if (mis_alloc) halt_q <= 1'b1;
      if (alloc) tail_q <= tail_q + PTR_W'(1);
      if (pop) head_q <= head_q + PTR_W'(1);
      alloc_cnt_q <= alloc_cnt_q + CNT_W'(alloc) - CNT_W'(pop);
      out_cnt_q   <= out_cnt_q + CNT_W'(issue) - CNT_W'(resp_fill);
      if (resp_drop) discard_cnt_q <= discard_cnt_q - CNT_W'(1);
    end
  end

  if_slot_ram #(.DEPTH(DEPTH)) u_slot_ram (
    .clk        (clk),
    .rst        (rst),
    .clear      (IF_Flush),
    .alloc_en   (alloc),
    .alloc_idx  (tail_q),
    .alloc_slot (alloc_slot),
    .fill_en    (resp_fill),
    .fill_idx   (fill_idx),
    .fill_instr (resp_data),
    .pop_en     (pop),
    .head_idx   (head_q),
    .head_slot  (head_slot)
  );

  assign IF_Instr      = IF_Valid ? head_slot.instr : '0;
  assign IF_PC         = IF_Valid ? head_slot.pc : '0;
  assign IF_ExceptType = IF_Valid ? head_slot.exc : '0;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: a simple in-order I-cache and a queue-level reference model.
module tb_if_fetch_queue;
  import if_fetch_queue_pkg::*;

  localparam logic [31:0] RST_PC = 32'hbfc0_0000;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            IF_Flush = 1'b0;
  logic [31:0]     IF_FlushPC = '0;
  logic            ID_Wr = 1'b0;
  logic            req_valid;
  logic [31:0]     req_addr;
  logic            req_ready = 1'b0;
  logic            resp_valid = 1'b0;
  logic [31:0]     resp_data = '0;
  logic            IF_Valid;
  logic [31:0]     IF_Instr;
  logic [31:0]     IF_PC;
  ExceptinPipeType IF_ExceptType;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
    bit          filled;
  } mslot_t;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
  } creq_t;

  mslot_t      mq[$];
  creq_t       cq[$];
  logic [31:0] m_pc = RST_PC;
  bit          m_halt = 1'b0;
  int          epoch = 0;
  int          accepts = 0;
  int          n_total = 0;
  int          n_fail = 0;

  if_fetch_queue dut (
    .clk           (clk),
    .rst           (rst),
    .IF_Flush      (IF_Flush),
    .IF_FlushPC    (IF_FlushPC),
    .ID_Wr         (ID_Wr),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_ready     (req_ready),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .IF_Valid      (IF_Valid),
    .IF_Instr      (IF_Instr),
    .IF_PC         (IF_PC),
    .IF_ExceptType (IF_ExceptType)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs at negedge, check outputs, then advance the model.
  task automatic cycle(input int p_ready, input int p_resp, input int p_idwr,
                       input bit do_flush, input logic [31:0] fpc);
    bit    exp_rv, hv;
    int    sz0;
    creq_t r;
    @(negedge clk);
    req_ready  = ($urandom_range(0, 99) < p_ready);
    resp_valid = (cq.size() > 0) && ($urandom_range(0, 99) < p_resp);
    resp_data  = resp_valid ? instr_of(cq[0].addr) : 32'h0;
    ID_Wr      = ($urandom_range(0, 99) < p_idwr);
    IF_Flush   = do_flush;
    IF_FlushPC = fpc;
    #1;
    sz0    = mq.size();
    exp_rv = !do_flush && !m_halt && (sz0 < 4) && (m_pc[1:0] == 2'b00);
    hv     = (sz0 > 0) && mq[0].filled;
    check("req_valid", 32'(req_valid), 32'(exp_rv));
    check("req_addr", req_addr, m_pc);
    check("IF_Valid", 32'(IF_Valid), 32'(hv));
    check("IF_PC", IF_PC, hv ? mq[0].pc : 32'h0);
    check("IF_Instr", IF_Instr, hv ? mq[0].instr : 32'h0);
    check("IF_ExceptType", 32'(IF_ExceptType.AddrErrFetch), hv ? 32'(mq[0].exc) : 32'h0);

    if (resp_valid) begin
      r = cq.pop_front();
      if (r.epoch == epoch) begin
        for (int i = 0; i < mq.size(); i++) begin
          if (!mq[i].filled) begin
            mq[i].filled = 1'b1;
            mq[i].instr  = resp_data;
            break;
          end
        end
      end
    end
    if (req_valid && req_ready) begin
      accepts++;
      cq.push_back('{addr: req_addr, epoch: epoch});
    end
    if (do_flush) begin
      mq.delete();
      epoch++;
      m_pc   = fpc;
      m_halt = 1'b0;
    end else begin
      if (ID_Wr && hv) void'(mq.pop_front());
      if (exp_rv && req_ready) begin
        mq.push_back('{pc: m_pc, instr: 32'h0, exc: 1'b0, filled: 1'b0});
        m_pc = m_pc + 32'd4;
      end else if (!m_halt && sz0 < 4 && m_pc[1:0] != 2'b00) begin
        mq.push_back('{pc: m_pc, instr: 32'h0, exc: 1'b1, filled: 1'b1});
        m_halt = 1'b1;
      end
    end
  endtask

  task automatic drain();
    repeat (12) cycle(0, 100, 100, 1'b0, 32'h0);
  endtask

  task automatic issue_n(input int n);
    for (int k = 0; k < 10 && cq.size() < n; k++) cycle(100, 0, 0, 1'b0, 32'h0);
    check("issue_bound", 32'(cq.size()), 32'(n));
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_valid", 32'(req_valid), 32'h0);
    check("rst_IF_Valid", 32'(IF_Valid), 32'h0);
    check("rst_IF_PC", IF_PC, 32'h0);
    check("rst_req_addr", req_addr, RST_PC);
    @(negedge clk);
    rst = 1'b1;

    // Stalled ID: exactly DEPTH requests accepted, then pops in order and fetch resumes
    accepts = 0;
    repeat (10) cycle(100, 100, 0, 1'b0, 32'h0);
    check("stall_accepts", 32'(accepts), 32'd4);
    repeat (12) cycle(100, 100, 100, 1'b0, 32'h0);

    // Flush with 2 outstanding
    drain();
    issue_n(2);
    cycle(0, 0, 100, 1'b1, 32'h8000_0100);
    repeat (20) cycle(100, 60, 70, 1'b0, 32'h0);

    // Flush coinciding with a response, 3 outstanding
    drain();
    issue_n(3);
    cycle(0, 100, 100, 1'b1, 32'h8000_0200);
    repeat (20) cycle(100, 60, 70, 1'b0, 32'h0);

    // Misaligned redirect: exception slot, fetch halted until the next flush
    cycle(100, 50, 50, 1'b1, 32'h8000_0102);
    repeat (5) cycle(100, 80, 0, 1'b0, 32'h0);
    repeat (10) cycle(100, 80, 100, 1'b0, 32'h0);
    cycle(100, 50, 50, 1'b1, 32'h8000_0300);

    // Random traffic with occasional redirects
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 99) < 3) begin
        logic [31:0] t;
        t = $urandom();
        if ($urandom_range(0, 9) != 0) t[1:0] = 2'b00;
        cycle($urandom_range(0, 100), $urandom_range(0, 100), $urandom_range(0, 100), 1'b1, t);
      end else begin
        cycle(70, 60, 60, 1'b0, 32'h0);
      end
    end

    // Async reset with 3 slots full
    cycle(100, 50, 50, 1'b1, 32'h8000_0400);
    for (int k = 0; k < 10 && !(mq.size() >= 3 && mq[2].filled); k++)
      cycle(100, 100, 0, 1'b0, 32'h0);
    cycle(0, 0, 0, 1'b0, 32'h0);
    check("three_full", 32'(mq.size() >= 3 && mq[2].filled), 32'h1);
    @(posedge clk);
    #2;
    resp_valid = 1'b0;
    ID_Wr      = 1'b0;
    rst        = 1'b0;
    #1;
    check("arst_IF_Valid", 32'(IF_Valid), 32'h0);
    check("arst_IF_PC", IF_PC, 32'h0);
    check("arst_IF_Instr", IF_Instr, 32'h0);
    check("arst_req_valid", 32'(req_valid), 32'h0);
    mq.delete();
    cq.delete();
    epoch++;
    m_pc   = RST_PC;
    m_halt = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (30) cycle(100, 70, 70, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
